// File: rtl/xb_fifo_dispatch_sched.sv
// xb_fifo_dispatch_sched
// Burst scheduler between the input sample FIFO and the bank of wavelet filter
// channels. A burst starts when the FIFO reports full. It reads BURST_LEN words and
// hands each word to the next non-busy channel in round-robin order.
//
// Handshake semantics:
//   FIFO side   : fifo_rdreq is asserted only when the FIFO is not empty and a
//                 channel is free. The word appears on fifo_q exactly one cycle later.
//   Channel side: ch_busy[k]=1 means channel k cannot take a word. It is sampled only
//                 when the grant is made. ch_wr is a one-hot strobe. ch_data is
//                 qualified by ch_wr and is valid in the same cycle.
// Read-to-strobe latency is fixed at two cycles. In debug, dbg_state and dbg_rr_ptr
// expose the FSM state and the round-robin pointer.
module xb_fifo_dispatch_sched #(
    parameter int N_CH      = 8,
    parameter int DW        = 16,
    parameter int BURST_LEN = 8
) (
    input  logic            phy_clk_0,
    input  logic            reset,
    input  logic            enable,
    input  logic            fifo_rdfull,
    input  logic            fifo_rdempty,
    input  logic [DW-1:0]   fifo_q,
    output logic            fifo_rdreq,
    input  logic [N_CH-1:0] ch_busy,
    output logic [DW-1:0]   ch_data,
    output logic [N_CH-1:0] ch_wr,
    output logic            burst_done,
    output logic [15:0]     words_sent,
    output logic [1:0]      dbg_state,
    output logic [3:0]      dbg_rr_ptr
);

    localparam int PW = (N_CH > 2) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [7:0]    beat_cnt;
    logic [PW-1:0] grant;
    logic          grant_vld;
    logic          s1_vld;
    logic [PW-1:0] s1_sel;
    logic          s2_vld;
    int unsigned   sum;
    logic [PW-1:0] idx;

    // Round-robin search: first free channel starting at rr_ptr, wrapping mod N_CH
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = 32'(rr_ptr) + 32'(i);
            if (sum >= 32'(N_CH)) sum = sum - 32'(N_CH);
            idx = PW'(sum);
            if (!grant_vld && !ch_busy[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    // An empty FIFO wins over a full flag. When all channels are busy, the read stalls.
    assign fifo_rdreq = (state == BURST) && !fifo_rdempty && grant_vld;

    // The pulse is high during the single DRAIN cycle in which the pipeline is empty
    assign burst_done = (state == DRAIN) && !s1_vld && !s2_vld;

    assign dbg_state  = state;
    assign dbg_rr_ptr = 4'(rr_ptr);

    // Burst control FSM. rr_ptr is not cleared between bursts, so the next burst resumes from it.
    always_ff @(posedge phy_clk_0) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && fifo_rdfull) begin
                        state    <= BURST;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (fifo_rdreq) begin
                        rr_ptr   <= (grant == PW'(N_CH - 1)) ? '0 : grant + PW'(1);
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == 8'(BURST_LEN - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_vld && !s2_vld) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage delivery pipeline. Stage 1 carries the grant while the FIFO word is in flight.
    always_ff @(posedge phy_clk_0) begin
        if (reset) begin
            s1_vld     <= 1'b0;
            s1_sel     <= '0;
            s2_vld     <= 1'b0;
            ch_wr      <= '0;
            ch_data    <= '0;
            words_sent <= '0;
        end else begin
            s1_vld <= fifo_rdreq;
            if (fifo_rdreq) s1_sel <= grant;
            s2_vld <= s1_vld;
            ch_wr  <= s1_vld ? (N_CH'(1) << s1_sel) : '0;
            if (s1_vld) begin
                ch_data    <= fifo_q;
                words_sent <= words_sent + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_xb_fifo_dispatch_sched.sv
// Directed bench for xb_fifo_dispatch_sched. A small FIFO model returns the
// queued word one cycle after each read. The sampler logs read, delivery and done
// events with their cycle numbers. Each test compares those logs with values
// worked out by hand.
module tb_xb_fifo_dispatch_sched;

    localparam int N_CH = 8;
    localparam int DW   = 16;
    localparam int W    = N_CH + DW;

    logic            phy_clk_0 = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            fifo_rdfull = 1'b0;
    logic            fifo_rdempty = 1'b0;
    logic [DW-1:0]   fifo_q = '0;
    logic            fifo_rdreq;
    logic [N_CH-1:0] ch_busy = '0;
    logic [DW-1:0]   ch_data;
    logic [N_CH-1:0] ch_wr;
    logic            burst_done;
    logic [15:0]     words_sent;
    logic [1:0]      dbg_state;
    logic [3:0]      dbg_rr_ptr;

    xb_fifo_dispatch_sched #(.N_CH(N_CH), .DW(DW), .BURST_LEN(8)) dut (
        .phy_clk_0   (phy_clk_0),
        .reset       (reset),
        .enable      (enable),
        .fifo_rdfull (fifo_rdfull),
        .fifo_rdempty(fifo_rdempty),
        .fifo_q      (fifo_q),
        .fifo_rdreq  (fifo_rdreq),
        .ch_busy     (ch_busy),
        .ch_data     (ch_data),
        .ch_wr       (ch_wr),
        .burst_done  (burst_done),
        .words_sent  (words_sent),
        .dbg_state   (dbg_state),
        .dbg_rr_ptr  (dbg_rr_ptr)
    );

    // Clock and watchdog
    always #5 phy_clk_0 = ~phy_clk_0;

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired before summary");
        $fatal(1, "watchdog");
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc_n = 0;
    int            words_exp = 0;
    logic          rd_prev = 1'b0;
    logic [DW-1:0] mem[$];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  del_q[$];
    int            rd_cyc[$];
    int            del_cyc[$];
    int            done_cyc[$];

    function automatic logic [W-1:0] mk(input int ch, input int d);
        logic [N_CH-1:0] oh;
        oh = N_CH'(1) << ch;
        return {oh, DW'(d)};
    endfunction

    // One clock cycle. The caller drives inputs at the negedge. The events of that
    // cycle are logged, and the FIFO model presents the word that was read.
    task automatic cyc();
        #1;
        if (fifo_rdreq) rd_cyc.push_back(cyc_n);
        if (ch_wr != '0) begin
            del_q.push_back({ch_wr, ch_data});
            del_cyc.push_back(cyc_n);
        end
        if (burst_done) done_cyc.push_back(cyc_n);
        rd_prev = fifo_rdreq;
        @(posedge phy_clk_0);
        @(negedge phy_clk_0);
        cyc_n++;
        if (rd_prev) begin
            if (mem.size() > 0) fifo_q = mem.pop_front();
            else fifo_q = 16'hDEAD;
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        del_q.delete();
        del_cyc.delete();
        done_cyc.delete();
        exp_q.delete();
    endtask

    task automatic load(input int base);
        mem.delete();
        for (int i = 0; i < 8; i++) mem.push_back(DW'(base + i));
    endtask

    task automatic set_exp(input int base, input int chs[8]);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(chs[i], base + i));
    endtask

    task automatic start_burst();
        enable = 1'b1;
        fifo_rdfull = 1'b1;
        cyc();
        fifo_rdfull = 1'b0;
    endtask

    task automatic test_reset();
        fifo_rdfull = 1'b1;
        enable = 1'b1;
        @(negedge phy_clk_0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ch_wr !== '0) begin errors++; $display("FAIL reset_ch_wr got %h want 00", ch_wr); end
            checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %b want 0", fifo_rdreq); end
            checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL reset_words got %0d want 0", words_sent); end
            checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", burst_done); end
            @(negedge phy_clk_0);
        end
        fifo_rdfull = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_full_burst();
        clear_logs();
        ch_busy = '0;
        load(16'h0010);
        start_burst();
        for (int k = 0; k < 60 && done_cyc.size() == 0; k++) cyc();
        set_exp(16'h0010, '{0, 1, 2, 3, 4, 5, 6, 7});
        checks++; if (rd_cyc.size() != 8) begin errors++; $display("FAIL full_reads got %0d want 8", rd_cyc.size()); end
        for (int i = 0; i < rd_cyc.size(); i++) begin
            checks++; if (rd_cyc[i] != rd_cyc[0] + i) begin errors++; $display("FAIL full_consec idx %0d got cyc %0d want %0d", i, rd_cyc[i], rd_cyc[0] + i); end
        end
        for (int i = 0; i < del_cyc.size() && i < rd_cyc.size(); i++) begin
            checks++; if (del_cyc[i] - rd_cyc[i] != 2) begin errors++; $display("FAIL full_latency idx %0d got %0d want 2", i, del_cyc[i] - rd_cyc[i]); end
        end
        checks++; if (del_q.size() != 8) begin errors++; $display("FAIL full_deliveries got %0d want 8", del_q.size()); end
        for (int i = 0; i < del_q.size() && i < 8; i++) begin
            checks++; if (del_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_word idx %0d got %h want %h", i, del_q[i], exp_q[i]); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", done_cyc.size()); end
        if (done_cyc.size() == 1 && rd_cyc.size() == 8) begin
            checks++; if (done_cyc[0] != rd_cyc[7] + 3) begin errors++; $display("FAIL full_done_time got %0d want %0d", done_cyc[0], rd_cyc[7] + 3); end
        end
        words_exp += 8;
        checks++; if (words_sent !== 16'(words_exp)) begin errors++; $display("FAIL full_words got %0d want %0d", words_sent, words_exp); end
        cyc(); cyc();
        checks++; if (del_q.size() != 8 || done_cyc.size() != 1) begin errors++; $display("FAIL full_quiet got del %0d done %0d want 8 1", del_q.size(), done_cyc.size()); end
    endtask

    task automatic test_all_busy();
        clear_logs();
        ch_busy = '0;
        load(16'h0040);
        start_burst();
        for (int k = 0; k < 20 && rd_cyc.size() < 4; k++) cyc();
        ch_busy = '1;
        repeat (3) cyc();
        ch_busy = '0;
        for (int k = 0; k < 60 && done_cyc.size() == 0; k++) cyc();
        set_exp(16'h0040, '{0, 1, 2, 3, 4, 5, 6, 7});
        checks++; if (rd_cyc.size() != 8) begin errors++; $display("FAIL busy_reads got %0d want 8", rd_cyc.size()); end
        if (rd_cyc.size() >= 5) begin
            checks++; if (rd_cyc[4] - rd_cyc[3] != 4) begin errors++; $display("FAIL busy_rd_gap got %0d want 4", rd_cyc[4] - rd_cyc[3]); end
        end
        if (del_cyc.size() >= 5) begin
            checks++; if (del_cyc[4] - del_cyc[3] != 4) begin errors++; $display("FAIL busy_wr_gap got %0d want 4", del_cyc[4] - del_cyc[3]); end
        end
        for (int i = 0; i < del_q.size() && i < 8; i++) begin
            checks++; if (del_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_word idx %0d got %h want %h", i, del_q[i], exp_q[i]); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL busy_done_pulses got %0d want 1", done_cyc.size()); end
        words_exp += 8;
        checks++; if (words_sent !== 16'(words_exp)) begin errors++; $display("FAIL busy_words got %0d want %0d", words_sent, words_exp); end
    endtask

    task automatic test_skip_busy();
        clear_logs();
        ch_busy = 8'b0000_0100;
        load(16'h0030);
        start_burst();
        for (int k = 0; k < 60 && done_cyc.size() == 0; k++) cyc();
        set_exp(16'h0030, '{0, 1, 3, 4, 5, 6, 7, 0});
        checks++; if (del_q.size() != 8) begin errors++; $display("FAIL skip_deliveries got %0d want 8", del_q.size()); end
        for (int i = 0; i < del_q.size() && i < 8; i++) begin
            checks++; if (del_q[i] !== exp_q[i]) begin errors++; $display("FAIL skip_word idx %0d got %h want %h", i, del_q[i], exp_q[i]); end
        end
        words_exp += 8;
        checks++; if (dbg_rr_ptr !== 4'd1) begin errors++; $display("FAIL skip_rr_ptr got %0d want 1", dbg_rr_ptr); end
    endtask

    task automatic test_rr_resume();
        clear_logs();
        ch_busy = '0;
        load(16'h0038);
        start_burst();
        for (int k = 0; k < 60 && done_cyc.size() == 0; k++) cyc();
        set_exp(16'h0038, '{1, 2, 3, 4, 5, 6, 7, 0});
        checks++; if (del_q.size() != 8) begin errors++; $display("FAIL resume_deliveries got %0d want 8", del_q.size()); end
        for (int i = 0; i < del_q.size() && i < 8; i++) begin
            checks++; if (del_q[i] !== exp_q[i]) begin errors++; $display("FAIL resume_word idx %0d got %h want %h", i, del_q[i], exp_q[i]); end
        end
        words_exp += 8;
        checks++; if (words_sent !== 16'(words_exp)) begin errors++; $display("FAIL resume_words got %0d want %0d", words_sent, words_exp); end
    endtask

    task automatic test_empty_stall();
        clear_logs();
        ch_busy = '0;
        load(16'h0050);
        start_burst();
        for (int k = 0; k < 20 && rd_cyc.size() < 3; k++) cyc();
        fifo_rdempty = 1'b1;
        fifo_rdfull = 1'b1;
        cyc(); cyc();
        fifo_rdempty = 1'b0;
        fifo_rdfull = 1'b0;
        for (int k = 0; k < 60 && done_cyc.size() == 0; k++) cyc();
        set_exp(16'h0050, '{1, 2, 3, 4, 5, 6, 7, 0});
        checks++; if (rd_cyc.size() != 8) begin errors++; $display("FAIL empty_reads got %0d want 8", rd_cyc.size()); end
        if (rd_cyc.size() >= 4) begin
            checks++; if (rd_cyc[3] - rd_cyc[2] != 3) begin errors++; $display("FAIL empty_rd_gap got %0d want 3", rd_cyc[3] - rd_cyc[2]); end
        end
        for (int i = 0; i < del_q.size() && i < 8; i++) begin
            checks++; if (del_q[i] !== exp_q[i]) begin errors++; $display("FAIL empty_word idx %0d got %h want %h", i, del_q[i], exp_q[i]); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL empty_done_pulses got %0d want 1", done_cyc.size()); end
        words_exp += 8;
        checks++; if (words_sent !== 16'(words_exp)) begin errors++; $display("FAIL empty_words got %0d want %0d", words_sent, words_exp); end
    endtask

    task automatic test_reset_mid_burst();
        clear_logs();
        ch_busy = '0;
        load(16'h0060);
        start_burst();
        for (int k = 0; k < 20 && rd_cyc.size() < 3; k++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (ch_wr !== '0) begin errors++; $display("FAIL midrst_ch_wr got %h want 00", ch_wr); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d want 0", dbg_state); end
        checks++; if (dbg_rr_ptr !== 4'd0) begin errors++; $display("FAIL midrst_rr_ptr got %0d want 0", dbg_rr_ptr); end
        checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL midrst_words got %0d want 0", words_sent); end
        checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL midrst_rdreq got %b want 0", fifo_rdreq); end
        clear_logs();
        repeat (3) cyc();
        checks++; if (del_q.size() != 0 || rd_cyc.size() != 0) begin errors++; $display("FAIL midrst_stray got del %0d rd %0d want 0 0", del_q.size(), rd_cyc.size()); end
        load(16'h0070);
        start_burst();
        for (int k = 0; k < 60 && done_cyc.size() == 0; k++) cyc();
        set_exp(16'h0070, '{0, 1, 2, 3, 4, 5, 6, 7});
        checks++; if (del_q.size() != 8) begin errors++; $display("FAIL midrst_deliveries got %0d want 8", del_q.size()); end
        for (int i = 0; i < del_q.size() && i < 8; i++) begin
            checks++; if (del_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word idx %0d got %h want %h", i, del_q[i], exp_q[i]); end
        end
        words_exp = 8;
        checks++; if (words_sent !== 16'(words_exp)) begin errors++; $display("FAIL midrst_words_after got %0d want %0d", words_sent, words_exp); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_full_burst();
        test_all_busy();
        test_skip_busy();
        test_rr_resume();
        test_empty_stall();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
